// File: rtl/nunchuck_input_conditioner.sv
// nunchuck_input_conditioner
//   Per-player front end between nunchuckDriver and game_state_updater.
//   Synchronises and debounces the Z/C buttons, edge-detects the VGA vsync
//   (foreign clock domain) and, once per frame, publishes a coherent snapshot:
//   dead-zoned, clamped signed stick velocities plus button presses latched
//   since the previous frame.
//
// Ports
//   clkin       in   system clock (same domain as nunchuckDriver)
//   rst         in   asynchronous reset, active-low
//   vsync       in   VGA vsync, active-low pulse, asynchronous to clkin
//   stick_x/y   in   raw 8-bit stick position (same clock domain, not synced)
//   z_in, c_in  in   raw buttons, 1 = pressed
//   frame_tick  out  one-cycle pulse; snapshot outputs change in this cycle
//   vel_x/y     out  signed VEL_W-bit velocity for the frame
//   z/c_level   out  debounced button level (continuous)
//   z/c_press   out  one-cycle pulse on debounced 0->1
//   z/c_frame   out  button pressed at least once during the previous frame
module nunchuck_input_conditioner #(
  parameter int CENTER          = 128,
  parameter int DEADZONE        = 16,
  parameter int SHIFT           = 3,
  parameter int MAX_SPEED       = 7,
  parameter int VEL_W           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                    clkin,
  input  logic                    rst,
  input  logic                    vsync,
  input  logic [7:0]              stick_x,
  input  logic [7:0]              stick_y,
  input  logic                    z_in,
  input  logic                    c_in,
  output logic                    frame_tick,
  output logic signed [VEL_W-1:0] vel_x,
  output logic signed [VEL_W-1:0] vel_y,
  output logic                    z_level,
  output logic                    c_level,
  output logic                    z_press,
  output logic                    c_press,
  output logic                    z_frame,
  output logic                    c_frame
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Offset from rest, dead zone, scale, clamp; magnitude is computed before
  // the sign is reapplied so the mapping is symmetric and never yields -0.
  function automatic logic signed [VEL_W-1:0] stick_to_vel(input logic [7:0] raw);
    int off;
    int mag;
    int m;
    off = int'(raw) - CENTER;
    mag = (off < 0) ? -off : off;
    if (mag <= DEADZONE) begin
      m = 0;
    end else begin
      m = (mag - DEADZONE) >>> SHIFT;
      if (m > MAX_SPEED) m = MAX_SPEED;
    end
    return (off < 0) ? VEL_W'(-m) : VEL_W'(m);
  endfunction

  // Button vectors are indexed {c, z}.
  logic [1:0]             btn_s1_q, btn_s2_q;
  logic [1:0]             stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q [2];
  logic [CNT_W-1:0]       cnt_d [2];
  logic [1:0]             press_q, press_d;
  logic [1:0]             sticky_q, sticky_d;
  logic [1:0]             frame_q, frame_d;
  logic                   vs1_q, vs2_q, vs3_q;
  logic                   tick_q, tick_d;
  logic [VEL_W-1:0]       velx_q, velx_d, vely_q, vely_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]    = '0;
        stable_d[i] = btn_s2_q[i];
        press_d[i]  = btn_s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Falling vsync seen on the synchronised copy; s3 only delays s2.
  assign tick_d = ~vs2_q & vs3_q;

  // A press pulse present at the tick edge is folded into the frame being
  // published, and the sticky flag restarts empty for the next frame.
  always_comb begin
    sticky_d = tick_d ? 2'b00 : (sticky_q | press_q);
    frame_d  = tick_d ? (sticky_q | press_q) : frame_q;
    velx_d   = tick_d ? stick_to_vel(stick_x) : velx_q;
    vely_d   = tick_d ? stick_to_vel(stick_y) : vely_q;
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      stable_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      press_q  <= '0;
      sticky_q <= '0;
      frame_q  <= '0;
      // Idle-high vsync history so reset release cannot look like a fall.
      vs1_q    <= 1'b1;
      vs2_q    <= 1'b1;
      vs3_q    <= 1'b1;
      tick_q   <= 1'b0;
      velx_q   <= '0;
      vely_q   <= '0;
    end else begin
      btn_s1_q <= {c_in, z_in};
      btn_s2_q <= btn_s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      sticky_q <= sticky_d;
      frame_q  <= frame_d;
      vs1_q    <= vsync;
      vs2_q    <= vs1_q;
      vs3_q    <= vs2_q;
      tick_q   <= tick_d;
      velx_q   <= velx_d;
      vely_q   <= vely_d;
    end
  end

  assign frame_tick = tick_q;
  assign vel_x      = velx_q;
  assign vel_y      = vely_q;
  assign z_level    = stable_q[0];
  assign c_level    = stable_q[1];
  assign z_press    = press_q[0];
  assign c_press    = press_q[1];
  assign z_frame    = frame_q[0];
  assign c_frame    = frame_q[1];

endmodule

// File: tb/tb_nunchuck_input_conditioner.sv
// Directed bench for nunchuck_input_conditioner with a short debounce window.
module tb_nunchuck_input_conditioner;

  localparam int DB = 8;

  logic             clkin = 1'b0;
  logic             rst, vsync, z_in, c_in;
  logic [7:0]       stick_x, stick_y;
  logic             frame_tick, z_level, c_level, z_press, c_press, z_frame, c_frame;
  logic signed [3:0] vel_x, vel_y;

  int n_cmp = 0;
  int n_err = 0;

  nunchuck_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clkin(clkin), .rst(rst), .vsync(vsync),
    .stick_x(stick_x), .stick_y(stick_y), .z_in(z_in), .c_in(c_in),
    .frame_tick(frame_tick), .vel_x(vel_x), .vel_y(vel_y),
    .z_level(z_level), .c_level(c_level), .z_press(z_press), .c_press(c_press),
    .z_frame(z_frame), .c_frame(c_frame)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " frame_tick"}, frame_tick, 0);
    check({tag, " vel_x"}, {28'd0, $unsigned(vel_x)}, 0);
    check({tag, " vel_y"}, {28'd0, $unsigned(vel_y)}, 0);
    check({tag, " z_level"}, z_level, 0);
    check({tag, " c_level"}, c_level, 0);
    check({tag, " z_press"}, z_press, 0);
    check({tag, " c_press"}, c_press, 0);
    check({tag, " z_frame"}, z_frame, 0);
    check({tag, " c_frame"}, c_frame, 0);
  endtask

  // vsync low sampled at edge N -> tick visible after edge N+2.
  task automatic vs_fall(input string tag);
    vsync = 1'b0;
    step(2);
    check({tag, " no early tick"}, frame_tick, 0);
    step(1);
    check({tag, " tick"}, frame_tick, 1);
  endtask

  task automatic vs_rise(input string tag);
    step(1);
    check({tag, " tick one cycle"}, frame_tick, 0);
    vsync = 1'b1;
    step(4);
  endtask

  task automatic check_vel(input string tag, input logic [3:0] ex, input logic [3:0] ey);
    check({tag, " vel_x"}, {28'd0, $unsigned(vel_x)}, {28'd0, ex});
    check({tag, " vel_y"}, {28'd0, $unsigned(vel_y)}, {28'd0, ey});
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b1; z_in = 1'b0; c_in = 1'b0;
    stick_x = 8'd128; stick_y = 8'd128;
    #2 rst = 1'b0;
    #2 check_all_zero("reset");
    step(3);
    rst = 1'b1;
    step(4);
    check("idle no tick", frame_tick, 0);

    // Full deflection both directions clamps to +/-7.
    stick_x = 8'd255; stick_y = 8'd0;
    vs_fall("t1");
    check_vel("t1", 4'd7, 4'h9);
    check("t1 z_frame", z_frame, 0);
    vs_rise("t1");

    stick_x = 8'd150; stick_y = 8'd200;
    vs_fall("t2a");
    check_vel("t2a", 4'd0, 4'd7);
    vs_rise("t2a");
    stick_x = 8'd180; stick_y = 8'd60;
    vs_fall("t2b");
    check_vel("t2b", 4'd4, 4'hA);
    vs_rise("t2b");
    stick_x = 8'd100; stick_y = 8'd144;
    vs_fall("t2c");
    check_vel("t2c", 4'hF, 4'd0);
    vs_rise("t2c");

    // Glitch of DB-2 cycles must not move the debounced level.
    z_in = 1'b1;
    for (int i = 0; i < DB - 2; i++) begin
      step(1);
      check("t3 glitch z_level", z_level, 0);
      check("t3 glitch z_press", z_press, 0);
    end
    z_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("t3 after glitch z_level", z_level, 0);
      check("t3 after glitch z_press", z_press, 0);
    end

    // Held press: 2 sync edges + DB debounce edges.
    z_in = 1'b1;
    step(DB + 1);
    check("t3 hold z_level early", z_level, 0);
    step(1);
    check("t3 hold z_level", z_level, 1);
    check("t3 hold z_press", z_press, 1);
    step(1);
    check("t3 z_press single", z_press, 0);
    check("t3 z_level held", z_level, 1);

    // Release before tick; release must produce no press pulse.
    z_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("t4 release z_press", z_press, 0);
    end
    check("t4 released z_level", z_level, 0);
    vs_fall("t4a");
    check("t4a z_frame", z_frame, 1);
    check("t4a c_frame", c_frame, 0);
    vs_rise("t4a");
    vs_fall("t4b");
    check("t4b z_frame", z_frame, 0);
    vs_rise("t4b");

    // Press pulse lands in the cycle just before the tick edge.
    z_in = 1'b1;
    step(DB);
    vsync = 1'b0;
    step(1);
    check("t5 z_press pre", z_press, 0);
    step(1);
    check("t5 z_press", z_press, 1);
    check("t5 no tick yet", frame_tick, 0);
    step(1);
    check("t5 tick", frame_tick, 1);
    check("t5 z_frame", z_frame, 1);
    vs_rise("t5");
    vs_fall("t5n");
    check("t5n z_frame", z_frame, 0);
    vs_rise("t5n");

    c_in = 1'b1;
    step(DB + 2);
    check("c c_level", c_level, 1);
    check("c c_press", c_press, 1);
    vs_fall("c");
    check("c c_frame", c_frame, 1);
    check("c z_frame", z_frame, 0);
    vs_rise("c");

    // Reset mid-debounce and mid-frame.
    z_in = 1'b0;
    step(DB + 4);
    z_in = 1'b1;
    stick_x = 8'd255;
    step(5);
    vsync = 1'b0;
    step(1);
    rst = 1'b0;
    #1;
    check_all_zero("t6 reset");
    z_in = 1'b0; c_in = 1'b0; vsync = 1'b1;
    step(3);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t6 no tick", frame_tick, 0);
      check("t6 z_level", z_level, 0);
    end
    vs_fall("t6");
    check_vel("t6", 4'd7, 4'd0);
    check("t6 z_frame", z_frame, 0);
    check("t6 c_frame", c_frame, 0);
    vs_rise("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
